ucie_ctl_sb_arb: RTL and testbench

UCIE_CTL_SB_ARB -- requirements
Module: UCIE_ctl_SB_ARB

---
 rtl/ucie_ctl_sb_arb.sv | 149 ++++++++++++++
 tb/tb_ucie_ctl_sb_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_sb_arb.sv
// Sideband message arbiter between the CNTL FSM (requester 0) and the
// error/log path (requester 1). Round-robin on ties, one message in flight,
// completion tracked via the sideband busy flag with a timeout fallback.
// CNT_W must satisfy 2**CNT_W > TIMEOUT_CYC.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for a request while the sideband is not busy
// SEND       | one-cycle strobe of the granted message, ack to winner
// WAIT_START | waiting for the sideband to go busy on our message
// WAIT_DONE  | waiting for the sideband to finish (busy falls)
module ucie_ctl_sb_arb #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_req0_valid,
  input  logic [4:0]  i_req0_decode,
  input  logic [31:0] i_req0_adv_cap,
  input  logic        i_req1_valid,
  input  logic [4:0]  i_req1_decode,
  input  logic        i_sb_busy_flag,
  output logic        o_req0_ack,
  output logic        o_req1_ack,
  output logic        o_sb_lp_valid,
  output logic [4:0]  o_sb_lp_decode,
  output logic [31:0] o_sb_lp_adv_cap_val,
  output logic        o_grant,
  output logic        o_arb_busy,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SEND       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req0_ack;
  logic             r_req1_ack;
  logic             r_valid;
  logic [4:0]       r_decode;
  logic [31:0]      r_adv_cap;
  logic             r_grant;
  logic             w_winner;
  logic             w_accept;
  logic             w_cnt_tc;
  logic             w_timeout;

  // Winner selection and accept qualification; a tie goes to the requester
  // that did not win last time.
  always_comb begin
    w_winner = (i_req0_valid & i_req1_valid) ? ~r_grant : i_req1_valid;
    w_accept = (r_state == ST_IDLE) & (i_req0_valid | i_req1_valid) &
               ~i_sb_busy_flag & ~i_flush;
    w_cnt_tc = (r_cnt == CNT_TC);
  end

  // Next-state logic; timeout loses to a normal completion and to flush.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    if (i_flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) w_state_nxt = ST_SEND;
        end
        ST_SEND: begin
          w_state_nxt = ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (w_cnt_tc) begin
            w_timeout   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (i_sb_busy_flag) begin
            w_state_nxt = ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (!i_sb_busy_flag) begin
            w_state_nxt = ST_IDLE;
          end else if (w_cnt_tc) begin
            w_timeout   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Timeout counter: cleared when a message is accepted, counts while waiting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_flush || w_accept) begin
      r_cnt <= '0;
    end else if (r_state == ST_WAIT_START || r_state == ST_WAIT_DONE) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered SEND-cycle strobes and the latched message, held until the next accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req0_ack <= 1'b0;
      r_req1_ack <= 1'b0;
      r_valid    <= 1'b0;
      r_decode   <= '0;
      r_adv_cap  <= '0;
      r_grant    <= 1'b1;
    end else begin
      r_req0_ack <= w_accept & ~w_winner;
      r_req1_ack <= w_accept & w_winner;
      r_valid    <= w_accept;
      if (w_accept) begin
        r_grant   <= w_winner;
        r_decode  <= w_winner ? i_req1_decode : i_req0_decode;
        r_adv_cap <= w_winner ? 32'h0 : i_req0_adv_cap;
      end
    end
  end

  assign o_req0_ack          = r_req0_ack;
  assign o_req1_ack          = r_req1_ack;
  assign o_sb_lp_valid       = r_valid;
  assign o_sb_lp_decode      = r_decode;
  assign o_sb_lp_adv_cap_val = r_adv_cap;
  assign o_grant             = r_grant;
  assign o_arb_busy          = (r_state != ST_IDLE);
  assign o_timeout           = w_timeout;

endmodule

// File: tb/tb_ucie_ctl_sb_arb.sv
// Scoreboard bench for the sideband arbiter: stimulus pushes expected
// messages and timeout cycles, a negedge monitor pops and compares.
module tb_ucie_ctl_sb_arb;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        r0v = 1'b0, r1v = 1'b0;
  logic [4:0]  r0d = '0, r1d = '0;
  logic [31:0] r0a = '0;
  logic        busy = 1'b0;
  logic        ack0, ack1, sbv, grant, abusy, tout;
  logic [4:0]  sbd;
  logic [31:0] sba;

  ucie_ctl_sb_arb #(.TIMEOUT_CYC(TO), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_req0_valid(r0v), .i_req0_decode(r0d), .i_req0_adv_cap(r0a),
    .i_req1_valid(r1v), .i_req1_decode(r1d), .i_sb_busy_flag(busy),
    .o_req0_ack(ack0), .o_req1_ack(ack1), .o_sb_lp_valid(sbv),
    .o_sb_lp_decode(sbd), .o_sb_lp_adv_cap_val(sba), .o_grant(grant),
    .o_arb_busy(abusy), .o_timeout(tout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          win;
    logic [4:0]  dec;
    logic [31:0] adv;
  } exp_t;

  exp_t exp_q[$];
  int   to_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   m_grant = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Monitor: every message strobe and every timeout pulse must be expected.
  always @(negedge clk) begin
    if (sbv) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_valid: decode %0h with empty scoreboard at cycle %0d", sbd, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("grant", {31'd0, grant}, {31'd0, e.win});
        chk("ack0", {31'd0, ack0}, {31'd0, !e.win});
        chk("ack1", {31'd0, ack1}, {31'd0, e.win});
        chk("decode", {27'd0, sbd}, {27'd0, e.dec});
        chk("adv_cap", sba, e.adv);
      end
    end else if (ack0 || ack1) begin
      chk("ack_without_valid", {30'd0, ack1, ack0}, 32'd0);
    end
    if (tout) begin
      if (to_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_timeout: pulse at cycle %0d", cyc);
      end else begin
        chk("timeout_cycle", cyc, to_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present requests for one accepting cycle (after 'pre' blocked cycles,
  // blocked by busy when pmode=0 or by flush when pmode=1).
  task automatic issue(input bit a, input bit b, input logic [4:0] d0,
                       input logic [31:0] a0, input logic [4:0] d1,
                       input int pre, input int pmode);
    exp_t e;
    r0v = a; r1v = b; r0d = d0; r0a = a0; r1d = d1;
    for (int k = 0; k < pre; k++) begin
      busy  = (pmode == 0);
      flush = (pmode == 1);
      tick();
    end
    busy = 1'b0; flush = 1'b0;
    e.win = (a && b) ? !m_grant : b;
    e.dec = e.win ? d1 : d0;
    e.adv = e.win ? 32'h0 : a0;
    m_grant = e.win;
    exp_q.push_back(e);
    tick();
    r0v = 1'b0; r1v = 1'b0;
    r0d = 5'($urandom); r0a = $urandom; r1d = 5'($urandom);
  endtask

  // Drive the wait phase from the SEND cycle (cycle 0): busy high in cycles
  // [s, s+h), optional flush in cycle f (0 = none).
  task automatic complete(input int s, input int h, input int f);
    bit normal;
    int e_cyc;
    int c0;
    c0 = cyc;
    normal = (s <= TO - 1) && (s + h <= TO);
    e_cyc  = normal ? s + h : TO;
    if (!normal && !(f >= 1 && f <= e_cyc)) to_q.push_back(c0 + TO);
    for (int k = 0; k < 16; k++) begin
      busy  = (k >= s) && (k < s + h);
      flush = (f != 0) && (k == f);
      tick();
    end
    busy = 1'b0; flush = 1'b0;
    tick();
    chk("idle_after_msg", {31'd0, abusy}, 32'd0);
  endtask

  initial begin
    // Reset state.
    tick(); tick();
    chk("rst_valid", {31'd0, sbv}, 32'd0);
    chk("rst_acks", {30'd0, ack1, ack0}, 32'd0);
    chk("rst_grant", {31'd0, grant}, 32'd1);
    chk("rst_busy", {31'd0, abusy}, 32'd0);
    chk("rst_timeout", {31'd0, tout}, 32'd0);
    chk("rst_decode", {27'd0, sbd}, 32'd0);
    chk("rst_adv", sba, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single req0 with the documented payload, clean completion.
    issue(1'b1, 1'b0, 5'h03, 32'hA5A5_0001, 5'h00, 0, 0);
    chk("send_busy", {31'd0, abusy}, 32'd1);
    complete(1, 1, 0);

    // Ties with a one-cycle busy pulse: grants must alternate.
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b1, 5'($urandom), $urandom, 5'($urandom), 0, 0);
      complete(1, 1, 0);
    end

    // req1 blocked by busy for 10 cycles, then served.
    issue(1'b0, 1'b1, 5'h00, 32'h0, 5'h1B, 10, 0);
    complete(2, 3, 0);

    // Flush during the sampling cycle: no accept, request kept and served next.
    issue(1'b1, 1'b0, 5'h11, 32'h1234_5678, 5'h00, 1, 1);
    complete(1, 2, 0);

    // Timeout with busy never rising.
    issue(1'b1, 1'b0, 5'h07, 32'hDEAD_BEEF, 5'h00, 0, 0);
    complete(99, 0, 0);

    // Busy falling exactly at terminal count: no timeout.
    issue(1'b0, 1'b1, 5'h00, 32'h0, 5'h09, 0, 0);
    complete(3, 5, 0);

    // Flush in WAIT_DONE with busy high.
    issue(1'b1, 1'b1, 5'h0A, 32'h0BAD_F00D, 5'h0C, 0, 0);
    busy = 1'b1; tick(); tick(); tick();
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("flush_idle", {31'd0, abusy}, 32'd0);
    chk("flush_no_timeout", {31'd0, tout}, 32'd0);
    busy = 1'b0; tick();

    // Reset asserted in the SEND cycle.
    r0v = 1'b1; r0d = 5'h15; r0a = 32'h5555_AAAA;
    tick();
    r0v = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, sbv}, 32'd0);
    chk("midrst_ack", {31'd0, ack0}, 32'd0);
    chk("midrst_grant", {31'd0, grant}, 32'd1);
    m_grant = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    issue(1'b1, 1'b0, 5'h02, 32'hCAFE_0002, 5'h00, 0, 0);
    complete(1, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      int pat;
      int f;
      pat = $urandom_range(1, 3);
      f = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 0;
      issue(pat[0], pat[1], 5'($urandom), $urandom, 5'($urandom),
            $urandom_range(0, 2), $urandom_range(0, 1));
      complete($urandom_range(1, 9), $urandom_range(1, 6), f);
    end

    tick(); tick();
    chk("exp_queue_empty", exp_q.size(), 32'd0);
    chk("timeout_queue_empty", to_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
